// File: rtl/main_memory_if.sv
// main_memory_if: cache/memory line-transfer handshake
interface main_memory_if;
  logic         cache2mem_valid;
  logic         cache2mem_rw;
  logic [31:0]  cache2mem_addr;
  logic [127:0] cache2mem_data;
  logic [127:0] mem2cache_data;
  logic         mem2cache_ready;
  modport master (
    output cache2mem_valid, cache2mem_rw, cache2mem_addr, cache2mem_data,
    input  mem2cache_data, mem2cache_ready
  );
  modport slave (
    input  cache2mem_valid, cache2mem_rw, cache2mem_addr, cache2mem_data,
    output mem2cache_data, mem2cache_ready
  );
endinterface

// File: rtl/main_memory.sv
// main_memory: line-granular memory model with a fixed programmable access latency
module main_memory #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input logic          clk,
  input logic          r,
  main_memory_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  typedef logic [127:0] image_t [DEPTH];
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  function automatic image_t init_image();
    image_t img;
    for (int i = 0; i < DEPTH; i++) img[i] = {4{32'(i)}};
    return img;
  endfunction
  image_t                mem = init_image();
  state_t                state;
  logic [7:0]            cnt;
  logic                  rw_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [127:0]          wdata_q;
  logic                  fire;
  assign fire = state == BUSY && cnt == 8'd0;
  // Accept a request, count down the latency, then complete with a one-cycle ready pulse
  always_ff @(posedge clk or negedge r)
    if (!r) begin
      state               <= IDLE;
      cnt                 <= '0;
      rw_q                <= 1'b0;
      idx_q               <= '0;
      wdata_q             <= '0;
      bus.mem2cache_ready <= 1'b0;
      bus.mem2cache_data  <= '0;
    end else
      case (state)
        IDLE:
          if (bus.cache2mem_valid) begin
            rw_q    <= bus.cache2mem_rw;
            idx_q   <= bus.cache2mem_addr[DEPTH_LOG2+3:4];
            wdata_q <= bus.cache2mem_data;
            cnt     <= 8'(LATENCY - 1);
            state   <= BUSY;
          end
        BUSY:
          if (fire) begin
            bus.mem2cache_ready <= 1'b1;
            if (!rw_q) bus.mem2cache_data <= mem[idx_q];
            state <= RESP;
          end else cnt <= cnt - 8'd1;
        default: begin
          bus.mem2cache_ready <= 1'b0;
          state               <= IDLE;
        end
      endcase
  // Array update lands at the completion edge; no reset so stored lines survive r
  always_ff @(posedge clk)
    if (fire && rw_q) mem[idx_q] <= wdata_q;
endmodule

// File: doc/main_memory.md
# main_memory

Line-granular main-memory model with a fixed, programmable access latency. It sits directly downstream of the direct-mapped cache and serves its refill (ALLOCATE) and write-back (WRITE_BACK) requests over the cache/memory handshake, one 128-bit line per transaction. Requests are latched on acceptance, then a latency counter runs. On completion the block performs the array access and pulses `mem2cache_ready` for exactly one cycle.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to the `mem2cache_ready` pulse; legal range 1..255.
- `DEPTH_LOG2`, default 10: log2 of the number of 128-bit lines stored.
- `clk` in 1: single clock, all logic on rising edge.
- `r` in 1: reset, asynchronous, active-low.
- `cache2mem_valid` in 1: request present.
- `cache2mem_rw` in 1: 1 = write line, 0 = read line.
- `cache2mem_addr` in 32: byte address; bits [3:0] ignored, line index = addr[DEPTH_LOG2+3:4], upper bits ignored (aliasing).
- `cache2mem_data` in 128: write line data.
- `mem2cache_data` out 128: read line data.
- `mem2cache_ready` out 1: one-cycle completion pulse, for both reads and writes.

## Operation
- Storage: 2^DEPTH_LOG2 x 128-bit array. The simulation initial image sets line i = four copies of the 32-bit value i. Reset does not alter the array.
- Registers: state, 8-bit latency counter, latched rw, latched line index, latched 128-bit write data.
- FSM states IDLE, BUSY, RESP:
  - IDLE: if `cache2mem_valid`=1 at the edge, latch rw, index and data; counter <= LATENCY-1; go to BUSY. Otherwise stay in IDLE.
  - BUSY: if counter==0, perform the access and go to RESP. For a read, `mem2cache_data` <= array[index]. For a write, array[index] <= latched data. In both cases `mem2cache_ready` <= 1. If counter!=0, decrement it.
  - RESP: `mem2cache_ready` <= 0; go to IDLE. `cache2mem_valid` is ignored in this state.
- Inputs are sampled only at acceptance. Changes to `cache2mem_*` during BUSY or RESP have no effect on the in-flight transaction.
- `mem2cache_data` holds its value until the next read completes. Writes never change it.
- A write to a line followed by a read of the same line returns the written data. The write lands in the array at the ready edge, before any later acceptance.
- `cache2mem_valid` need not drop between transactions. A request still asserted when the block re-enters IDLE is accepted on the next edge. This supports the cache's WRITE_BACK -> ALLOCATE back-to-back sequence.

## Timing
- Reset asserted (r=0): immediate and asynchronous. State=IDLE, counter=0, `mem2cache_ready`=0, `mem2cache_data`=0, latched fields=0.
- Reset mid-transaction: the transaction is aborted. A pending write is discarded and the array is unchanged. No ready pulse occurs.
- First acceptance is possible at the first rising edge after r deasserts.
- Acceptance at edge E0 makes `mem2cache_ready` high from edge E0+LATENCY to edge E0+LATENCY+1. For reads, `mem2cache_data` is valid from edge E0+LATENCY.
- The earliest next acceptance is edge E0+LATENCY+2, so throughput is one line per LATENCY+2 cycles.
- LATENCY=1 gives ready one cycle after acceptance.
- `mem2cache_ready` is never high on two consecutive cycles.

## Test plan
- Reset and idle: hold r=0 for 3 cycles, then release with valid=0 for 10 cycles -> ready stays 0 and data stays 128'h0 throughout.
- Read initial image: LATENCY=4; read addr 32'h0000_0050, accepted at E0 -> ready high exactly for cycle E0+4..E0+5; data=128'h00000005_00000005_00000005_00000005; data held afterwards.
- Write then read: write addr 32'h0000_0120 with data 128'hDEADBEEF_0000000F_CAFEF00D_12345678, then read the same address -> ready pulses for both; the read returns the written value; data is unchanged between the write's ready and the read's ready.
- Back-to-back with valid held high: write-back to line 3 immediately followed by a read of line 7, valid never deasserted -> two ready pulses spaced LATENCY+2 cycles apart; the read returns 128'h00000007 x4.
- Reset mid-operation: accept a write of 128'h1 to line 9, assert r=0 two cycles later -> no ready pulse; after release, a read of line 9 returns 128'h00000009 x4.
- Input change during BUSY and aliasing: change addr and rw during BUSY -> the original transaction completes unaffected. Separately, read addr 32'h0000_4050 (DEPTH_LOG2=10) -> returns line 5 contents.
